riscv_dmem_responder: RTL

- Data-memory responder for the RISC-V core: the memory end of the core's load/store interface. It serves the lw/sw (plus byte/half) traffic that the core datapath issues.
- Accepts one request at a time over a valid/ready handshake and performs the access after a programmable latency.
- Returns the loaded data, or an error flag, over a valid/ready response channel.
- Sits between the core's MEM stage and a word-organised, little-endian RAM held inside the block.

---
 rtl/riscv_dmem_responder_if.sv | 40 ++++
 rtl/riscv_dmem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder_if.sv
// Load/store bus between the core MEM stage and the data-memory responder.
// Request channel carries one access; response channel returns data or error.
interface riscv_dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid,
      input  req_ready,
      output req_we,
      output req_funct3,
      output req_addr,
      output req_wdata,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_rdata,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      output req_ready,
      input  req_we,
      input  req_funct3,
      input  req_addr,
      input  req_wdata,
      output rsp_valid,
      input  rsp_ready,
      output rsp_rdata,
      output rsp_err
   );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed latency,
// little-endian word RAM, byte/half lanes, error on bad accesses.
module riscv_dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input logic                   clk,
   input logic                   rst,
   riscv_dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          accept;
   logic          exec;
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [31:0]   shifted;
   logic [7:0]    b8;
   logic [15:0]   h16;
   logic [31:0]   ld_val;
   logic [31:0]   wr_mask;
   logic [31:0]   wr_data;
   logic [31:0]   wr_word;
   logic          bad_f3;
   logic          misal;
   logic          oor;
   logic          err;

   assign accept = bus.req_valid && (state_q == IDLE);
   assign exec   = (state_q == BUSY) && (cnt_q == 4'd0);

   // Decode the captured request: error checks, load extract, store merge
   always_comb begin
      idx     = addr_q[AW+1:2];
      word    = mem[idx];
      oor     = |addr_q[31:AW+2];
      misal   = 1'b0;
      if (f3_q[1:0] == 2'b01) misal = addr_q[0];
      if (f3_q[1:0] == 2'b10) misal = |addr_q[1:0];
      if (we_q) bad_f3 = f3_q[2] || (f3_q[1:0] == 2'b11);
      else      bad_f3 = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110);
      err     = bad_f3 || misal || oor;
      shifted = word >> {addr_q[1:0], 3'b000};
      b8      = shifted[7:0];
      h16     = addr_q[1] ? word[31:16] : word[15:0];
      ld_val  = word;
      wr_mask = 32'hFFFF_FFFF;
      wr_data = wdata_q;
      unique case (f3_q[1:0])
         2'b00: begin
            ld_val  = {{24{b8[7] & ~f3_q[2]}}, b8};
            wr_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            wr_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            ld_val  = {{16{h16[15] & ~f3_q[2]}}, h16};
            wr_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            wr_data = {2{wdata_q[15:0]}};
         end
         default: begin
            ld_val  = word;
            wr_mask = 32'hFFFF_FFFF;
            wr_data = wdata_q;
         end
      endcase
      wr_word = (word & ~wr_mask) | (wr_data & wr_mask);
   end

   // RAM write at the execute edge; a coincident reset cancels it
   always_ff @(posedge clk) begin
      if (!rst && exec && we_q && !err) mem[idx] <= wr_word;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req_valid)   state_d = BUSY;
         BUSY:    if (cnt_q == 4'd0)   state_d = RESP;
         RESP:    if (bus.rsp_ready)   state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Capture on accept, count down in BUSY, register result on execute
   always_comb begin
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         cnt_d   = 4'(LATENCY - 1);
         we_d    = bus.req_we;
         f3_d    = bus.req_funct3;
         addr_d  = bus.req_addr;
         wdata_d = bus.req_wdata;
      end
      if ((state_q == BUSY) && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
      if (exec) begin
         err_d   = err;
         rdata_d = (err || we_q) ? 32'd0 : ld_val;
      end
   end

   // Handshake outputs
   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.rsp_valid = (state_q == RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
   end
endmodule
